// File: rtl/approx_err_monitor_if.sv
// rtl/approx_err_monitor_if.sv - sample and report handshake bundle for approx_err_monitor
interface approx_err_monitor_if #(
  parameter int N        = 8,
  parameter int WIN_LOG2 = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0]          A;
  logic [N-1:0]          B;
  logic [N-1:0]          approx_sum;
  logic                  rpt_valid;
  logic                  rpt_ready;
  logic [WIN_LOG2:0]     err_count;
  logic [N+WIN_LOG2:0]   ed_sum;
  logic [N:0]            ed_max;
  logic [N:0]            mean_ed;

  modport master (
    output in_valid, A, B, approx_sum, rpt_ready,
    input  in_ready, rpt_valid, err_count, ed_sum, ed_max, mean_ed
  );

  modport slave (
    input  in_valid, A, B, approx_sum, rpt_ready,
    output in_ready, rpt_valid, err_count, ed_sum, ed_max, mean_ed
  );
endinterface

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - windowed error count / distance accumulator for approximate adders
module approx_err_monitor #(
  parameter int N        = 8,
  parameter int WIN_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_err_monitor_if.slave  bus
);
  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;
  localparam int         SW        = N + 1 + WIN_LOG2;

  logic [1:0]          r_state;
  logic [WIN_LOG2-1:0] r_smp_cnt;
  logic                r_s1_v;
  logic                r_s1_err;
  logic [N:0]          r_s1_ed;
  logic [WIN_LOG2:0]   r_err_count;
  logic [SW-1:0]       r_ed_sum;
  logic [N:0]          r_ed_max;

  logic [N:0]          w_exact;
  logic [N:0]          w_apx;
  logic [N:0]          w_ed;
  logic                w_accept;
  logic                w_last;
  logic                w_rpt_take;

  // A dropped carry-out of the adder under test shows up as a 2^N distance.
  assign w_exact    = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_apx      = {1'b0, bus.approx_sum};
  assign w_ed       = (w_exact >= w_apx) ? (w_exact - w_apx) : (w_apx - w_exact);
  assign w_accept   = bus.in_valid && (r_state == S_COLLECT);
  assign w_last     = (r_smp_cnt == {WIN_LOG2{1'b1}});
  assign w_rpt_take = (r_state == S_REPORT) && bus.rpt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_COLLECT;
      r_smp_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_smp_cnt <= r_smp_cnt + 1'b1;
      end
      case (r_state)
        S_COLLECT: if (w_accept && w_last) r_state <= S_DRAIN;
        S_DRAIN:   r_state <= S_REPORT;
        S_REPORT:  if (bus.rpt_ready) r_state <= S_COLLECT;
        default:   r_state <= S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_err <= 1'b0;
      r_s1_ed  <= '0;
    end else begin
      r_s1_v <= w_accept && !w_rpt_take;
      if (w_accept) begin
        r_s1_ed  <= w_ed;
        r_s1_err <= |w_ed;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
    end else if (w_rpt_take) begin
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
    end else if (r_s1_v) begin
      r_err_count <= r_err_count + {{WIN_LOG2{1'b0}}, r_s1_err};
      r_ed_sum    <= r_ed_sum + SW'(r_s1_ed);
      if (r_s1_ed > r_ed_max) begin
        r_ed_max <= r_s1_ed;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_COLLECT);
  assign bus.rpt_valid = (r_state == S_REPORT);
  assign bus.err_count = r_err_count;
  assign bus.ed_sum    = r_ed_sum;
  assign bus.ed_max    = r_ed_max;
  assign bus.mean_ed   = r_ed_sum[SW-1:WIN_LOG2];
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - randomized and directed bench for approx_err_monitor
module tb_approx_err_monitor;
  localparam int N   = 8;
  localparam int W   = 2;
  localparam int WIN = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  approx_err_monitor_if #(.N(N), .WIN_LOG2(W)) bus ();
  approx_err_monitor_if #(.N(8), .WIN_LOG2(4)) bus_w ();

  approx_err_monitor #(.N(N), .WIN_LOG2(W)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  approx_err_monitor #(.N(8), .WIN_LOG2(4)) u_wide (.clk(clk), .rst(rst), .bus(bus_w));

  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list of distances of the current window plus "window full" bookkeeping.
  int m_eds[$];
  int m_cnt   = 0;
  bit m_full  = 0;
  int m_since = 0;
  bit m_clr   = 0;

  function automatic int ed_of(int a, int b, int s);
    int d = a + b - s;
    return (d < 0) ? -d : d;
  endfunction

  function automatic int m_err();
    int c = 0;
    foreach (m_eds[i]) if (m_eds[i] != 0) c++;
    return c;
  endfunction

  function automatic int m_sum();
    int c = 0;
    foreach (m_eds[i]) c += m_eds[i];
    return c;
  endfunction

  function automatic int m_max();
    int c = 0;
    foreach (m_eds[i]) if (m_eds[i] > c) c = m_eds[i];
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_eds.delete();
      m_cnt   = 0;
      m_full  = 0;
      m_since = 0;
      m_clr   = 0;
    end else begin
      m_clr = 0;
      if (m_full) begin
        if (m_since >= 1 && bus.rpt_ready) begin
          m_full = 0;
          m_eds.delete();
          m_cnt  = 0;
          m_clr  = 1;
        end else begin
          m_since++;
        end
      end else if (bus.in_valid) begin
        m_eds.push_back(ed_of(int'(bus.A), int'(bus.B), int'(bus.approx_sum)));
        m_cnt++;
        if (m_cnt == WIN) begin
          m_full  = 1;
          m_since = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", bus.in_ready, !m_full);
      chk("rpt_valid", bus.rpt_valid, m_full && m_since >= 1);
      if (m_full && m_since >= 1) begin
        chk("err_count", bus.err_count, m_err());
        chk("ed_sum", bus.ed_sum, m_sum());
        chk("ed_max", bus.ed_max, m_max());
        chk("mean_ed", bus.mean_ed, m_sum() >> W);
      end
      if (m_clr) begin
        chk("clr_err_count", bus.err_count, 0);
        chk("clr_ed_sum", bus.ed_sum, 0);
        chk("clr_ed_max", bus.ed_max, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(bit v, int a, int b, int s);
    bus.in_valid   = v;
    bus.A          = a[7:0];
    bus.B          = b[7:0];
    bus.approx_sum = s[7:0];
    cyc();
  endtask

  task automatic rand_put(bit v);
    int a  = int'($urandom_range(0, 255));
    int b  = int'($urandom_range(0, 255));
    int ex = a + b;
    int s;
    case ($urandom_range(0, 3))
      0:       s = ex & 255;
      1:       s = (ex ^ int'($urandom_range(0, 7))) & 255;
      2:       s = int'($urandom_range(0, 255));
      default: s = (ex > 255) ? (ex & 255) : ex;
    endcase
    put(v, a, b, s);
  endtask

  task automatic wait_rpt(output int n);
    n = 0;
    while (!bus.rpt_valid && n < 40) begin
      cyc();
      n++;
    end
    if (!bus.rpt_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_rpt: rpt_valid never rose within %0d cycles", n);
    end
  endtask

  task automatic take();
    bus.rpt_ready = 1'b1;
    cyc();
    bus.rpt_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.approx_sum = 0; bus.rpt_ready = 0;
    bus_w.in_valid = 0; bus_w.A = 0; bus_w.B = 0; bus_w.approx_sum = 0; bus_w.rpt_ready = 0;
    cyc(); cyc();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_rpt_valid", bus.rpt_valid, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_ed_sum", bus.ed_sum, 0);
    chk("rst_ed_max", bus.ed_max, 0);
    chk("rst_mean_ed", bus.mean_ed, 0);
    rst = 1'b0;

    // exact samples
    put(1, 3, 4, 7); put(1, 10, 20, 30); put(1, 0, 0, 0); put(1, 100, 27, 127);
    bus.in_valid = 0;
    wait_rpt(n);
    chk("t1_latency", n, 1);
    chk("t1_err_count", bus.err_count, 0);
    chk("t1_ed_sum", bus.ed_sum, 0);
    chk("t1_ed_max", bus.ed_max, 0);
    take();

    // mixed errors, then report backpressure
    put(1, 200, 100, 44); put(1, 1, 1, 3); put(1, 5, 5, 8); put(1, 7, 1, 8);
    bus.in_valid = 0;
    wait_rpt(n);
    chk("t2_err_count", bus.err_count, 3);
    chk("t2_ed_sum", bus.ed_sum, 259);
    chk("t2_ed_max", bus.ed_max, 256);
    chk("t2_mean_ed", bus.mean_ed, 64);
    chk("t2_model_sum", m_sum(), 259);
    chk("t2_model_max", m_max(), 256);
    for (int i = 0; i < 10; i++) rand_put(1);
    chk("t3_in_ready_held", bus.in_ready, 0);
    chk("t3_ed_sum_held", bus.ed_sum, 259);
    take();
    chk("t3_in_ready_after", bus.in_ready, 1);
    chk("t3_ed_sum_after", bus.ed_sum, 0);
    chk("t3_mean_after", bus.mean_ed, 0);
    bus.in_valid = 0;

    // gapped input
    for (int i = 0; i < 8; i++) rand_put(i % 2 == 0);
    bus.in_valid = 0;
    wait_rpt(n);
    chk("t4_latency", n, 0);
    chk("t4_model_cnt", m_eds.size(), 4);
    take();

    // reset mid-window, then during REPORT
    rand_put(1); rand_put(1);
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", bus.in_ready, 1);
    chk("t5_rst_ed_sum", bus.ed_sum, 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rand_put(1);
    bus.in_valid = 0;
    wait_rpt(n);
    chk("t5_model_cnt", m_eds.size(), 4);
    take();
    for (int i = 0; i < 4; i++) rand_put(1);
    bus.in_valid = 0;
    wait_rpt(n);
    rst = 1'b1;
    #1;
    chk("t5_rpt_rst_valid", bus.rpt_valid, 0);
    chk("t5_rpt_rst_ready", bus.in_ready, 1);
    chk("t5_rpt_rst_ed_sum", bus.ed_sum, 0);
    #1;
    rst = 1'b0;

    // random traffic with random report backpressure
    for (int i = 0; i < 400; i++) begin
      bus.rpt_ready = ($urandom_range(0, 1) == 1);
      rand_put($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 0;
    bus.rpt_ready = 0;
    cyc(); cyc();

    // worst-case width on the 16-sample instance
    for (int i = 0; i < 16; i++) begin
      bus_w.in_valid = 1; bus_w.A = 8'd255; bus_w.B = 8'd255; bus_w.approx_sum = 8'd0;
      cyc();
    end
    bus_w.in_valid = 0;
    n = 0;
    while (!bus_w.rpt_valid && n < 40) begin
      cyc();
      n++;
    end
    chk("t6_rpt_valid", bus_w.rpt_valid, 1);
    chk("t6_err_count", bus_w.err_count, 16);
    chk("t6_ed_sum", bus_w.ed_sum, 8160);
    chk("t6_ed_max", bus_w.ed_max, 510);
    chk("t6_mean_ed", bus_w.mean_ed, 510);
    bus_w.rpt_ready = 1;
    cyc();
    bus_w.rpt_ready = 0;
    chk("t6_in_ready_after", bus_w.in_ready, 1);
    chk("t6_ed_sum_after", bus_w.ed_sum, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
